// File: rtl/bitonic_sort_sched_if.sv
// Client request and engine control bundle for the bitonic sort job scheduler.
// The scheduler takes the slave view; clients and the engine take the master view.
interface bitonic_sort_sched_if #(
  parameter int NREQ = 4,
  parameter int ADDR = 12,
  parameter int CNTW = 13
) ();
  logic [NREQ-1:0]      req;
  logic [NREQ*ADDR-1:0] req_addr;
  logic [NREQ*CNTW-1:0] req_cnt;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      err;
  logic                 busy;
  logic                 sort_req;
  logic [ADDR-1:0]      start_addr;
  logic [CNTW-1:0]      data_count;
  logic                 sort_active;
  logic                 sort_valid;

  modport slave (
    input  req, req_addr, req_cnt, sort_active, sort_valid,
    output gnt, done, err, busy, sort_req, start_addr, data_count
  );

  modport master (
    output req, req_addr, req_cnt, sort_active, sort_valid,
    input  gnt, done, err, busy, sort_req, start_addr, data_count
  );
endinterface

// File: rtl/bitonic_sort_sched.sv
// Round-robin job scheduler for the shared bitonic sort engine: grants one
// client at a time, launches the engine, counts output beats against the
// expected total and returns a per-client done or err pulse.
module bitonic_sort_sched #(
  parameter int NREQ = 4,
  parameter int ADDR = 12,
  parameter int CNTW = 13,
  parameter int TMO  = 1024
) (
  input  logic                clk,
  input  logic                rstb,
  bitonic_sort_sched_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TMO + 1);
  localparam int BW = 2 * CNTW;

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, FINISH} state_t;

  state_t          state, state_nx;
  logic [NREQ-1:0] gnt, gnt_nx, done, done_nx, err, err_nx;
  logic            sort_req, sort_req_nx, fin_err, fin_err_nx;
  logic [ADDR-1:0] start_addr, start_addr_nx;
  logic [CNTW-1:0] data_count, data_count_nx;
  logic [BW-1:0]   exp_beats, exp_beats_nx, beat_cnt, beat_cnt_nx, beat_inc;
  logic [WW-1:0]   wdog, wdog_nx;
  logic [IW-1:0]   rr_ptr, rr_ptr_nx, gidx, gidx_nx;
  logic [IW-1:0]   win, cand;
  logic            win_vld;
  logic [ADDR-1:0] win_addr;
  logic [CNTW-1:0] win_cnt;
  logic [BW-1:0]   win_cnt_w;
  logic            wdog_exp;

  // Round-robin search starting one past the last granted client, plus winner operand mux.
  always_comb begin
    win      = '0;
    win_vld  = 1'b0;
    cand     = '0;
    win_addr = '0;
    win_cnt  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!win_vld && bus.req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win == IW'(k)) begin
        win_addr = bus.req_addr[k*ADDR +: ADDR];
        win_cnt  = bus.req_cnt[k*CNTW +: CNTW];
      end
    end
  end

  assign win_cnt_w = {{CNTW{1'b0}}, win_cnt};
  assign beat_inc  = (bus.sort_valid && (beat_cnt != '1)) ? beat_cnt + 1'b1 : beat_cnt;
  assign wdog_exp  = (wdog == WW'(TMO - 1));

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_nx      = state;
    gnt_nx        = gnt;
    done_nx       = '0;
    err_nx        = '0;
    sort_req_nx   = sort_req;
    fin_err_nx    = fin_err;
    start_addr_nx = start_addr;
    data_count_nx = data_count;
    exp_beats_nx  = exp_beats;
    beat_cnt_nx   = beat_cnt;
    rr_ptr_nx     = rr_ptr;
    gidx_nx       = gidx;
    case (state)
      IDLE: begin
        if (win_vld && !bus.sort_active) begin
          gnt_nx        = NREQ'(1) << win;
          gidx_nx       = win;
          start_addr_nx = win_addr;
          data_count_nx = win_cnt;
          exp_beats_nx  = win_cnt_w * win_cnt_w;
          beat_cnt_nx   = '0;
          if (win_cnt == '0) begin
            fin_err_nx = 1'b1;
            state_nx   = FINISH;
          end else begin
            fin_err_nx  = 1'b0;
            sort_req_nx = 1'b1;
            state_nx    = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (bus.sort_active) begin
          sort_req_nx = 1'b0;
          state_nx    = RUN;
        end else if (wdog_exp) begin
          sort_req_nx = 1'b0;
          fin_err_nx  = 1'b1;
          state_nx    = FINISH;
        end
      end
      RUN: begin
        beat_cnt_nx = beat_inc;
        if (beat_inc > exp_beats) begin
          fin_err_nx = 1'b1;
          state_nx   = FINISH;
        end else if (!bus.sort_active) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        beat_cnt_nx = beat_inc;
        if (beat_inc > exp_beats) begin
          fin_err_nx = 1'b1;
          state_nx   = FINISH;
        end else if (beat_inc == exp_beats) begin
          fin_err_nx = 1'b0;
          state_nx   = FINISH;
        end else if (wdog_exp && !bus.sort_valid) begin
          fin_err_nx = 1'b1;
          state_nx   = FINISH;
        end
      end
      FINISH: begin
        done_nx   = fin_err ? '0 : gnt;
        err_nx    = fin_err ? gnt : '0;
        gnt_nx    = '0;
        rr_ptr_nx = gidx;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Watchdog restarts on any state change or beat and only runs while waiting on the engine.
    if ((state_nx != state) || bus.sort_valid) begin
      wdog_nx = '0;
    end else if ((state == LAUNCH) || (state == DRAIN)) begin
      wdog_nx = wdog + 1'b1;
    end else begin
      wdog_nx = '0;
    end
  end

  // State, output and counter registers; reset aborts any job silently.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      err        <= '0;
      sort_req   <= 1'b0;
      fin_err    <= 1'b0;
      start_addr <= '0;
      data_count <= '0;
      exp_beats  <= '0;
      beat_cnt   <= '0;
      wdog       <= '0;
      rr_ptr     <= '0;
      gidx       <= '0;
    end else begin
      state      <= state_nx;
      gnt        <= gnt_nx;
      done       <= done_nx;
      err        <= err_nx;
      sort_req   <= sort_req_nx;
      fin_err    <= fin_err_nx;
      start_addr <= start_addr_nx;
      data_count <= data_count_nx;
      exp_beats  <= exp_beats_nx;
      beat_cnt   <= beat_cnt_nx;
      wdog       <= wdog_nx;
      rr_ptr     <= rr_ptr_nx;
      gidx       <= gidx_nx;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.busy       = (state != IDLE);
  assign bus.sort_req   = sort_req;
  assign bus.start_addr = start_addr;
  assign bus.data_count = data_count;

endmodule

// File: doc/bitonic_sort_sched.md
Name: bitonic_sort_sched

Overview:
- Job scheduler in front of the shared bitonic sort engine. Up to NREQ clients each post a sort job (start address and row count), and the block grants the engine round-robin.
- For the granted job it drives the engine's sort_req/start_addr/data_count, tracks engine activity and output beats, and returns a per-client done/error pulse.
- Sits between the client request ports and the engine's control inputs. The SRAM data path is untouched.

Parameters:
NREQ, 4, number of requesting clients (2..8)
ADDR, 12, SRAM address width, equal to the engine ADDR
CNTW, 13, job row-count width (ADDR+1)
TMO, 1024, watchdog limit in cycles for launch and drain phases

Ports:
clk  in  1  clock
rstb  in  1  synchronous active-low reset
req  in  NREQ  per-client job request, level, held until done/err pulse
req_addr  in  NREQ*ADDR  per-client job start row address
req_cnt  in  NREQ*CNTW  per-client job length in rows (WIDTH entries per row)
gnt  out  NREQ  one-hot grant, high for the whole job
done  out  NREQ  one-cycle pulse, job completed correctly
err  out  NREQ  one-cycle pulse, job rejected or watchdog expired
busy  out  1  scheduler not in IDLE
sort_req  out  1  to engine sort_req
start_addr  out  ADDR  to engine start_addr, stable while gnt high
data_count  out  CNTW  to engine data_count (zero-extended), stable while gnt high
sort_active  in  1  from engine
sort_valid  in  1  from engine, one per output beat

Behaviour:
- Single clock clk. Reset is synchronous and active-low on rstb; all flops update on rising clk.
- Reset values:
  - State IDLE.
  - gnt, done, err, busy and sort_req are 0.
  - start_addr and data_count are 0.
  - RR pointer at 0; all counters 0.
- States: IDLE, LAUNCH, RUN, DRAIN, FINISH.
- IDLE:
  - If any req is high and sort_active is 0, choose a winner round-robin, starting the search at the index after the last granted client.
  - Register gnt, start_addr and data_count from the winner's inputs.
  - Load exp_beats = req_cnt*req_cnt (2*CNTW-bit product); this is the engine's beat count for a full job.
  - Grant is visible the cycle after req is sampled.
  - If the winner's req_cnt is 0: no launch, go to FINISH with the error flag set.
  - Otherwise go to LAUNCH with sort_req=1.
- LAUNCH:
  - sort_req stays high until sort_active is sampled 1. sort_req then drops in the next cycle, so the engine stops at its final pass wrap. Go to RUN.
  - If the watchdog reaches TMO first, go to FINISH with error.
- RUN:
  - Count sort_valid beats (2*CNTW-bit counter, saturating).
  - When sort_active falls, go to DRAIN.
- DRAIN:
  - Keep counting beats.
  - When beat_cnt == exp_beats, go to FINISH, ok.
  - If the watchdog reaches TMO, go to FINISH, error.
  - A beat count above exp_beats at any point is an error (go to FINISH, error).
- FINISH (1 cycle):
  - Pulse done[i] or err[i] for the granted index.
  - Clear gnt and update the RR pointer to the granted index.
  - Return to IDLE. This guarantees at least 1 idle cycle between jobs.
- Watchdog: resets to 0 on every state change and on every sort_valid beat. It counts only in LAUNCH and DRAIN.
- Requests:
  - req deassertion by the granted client mid-job is ignored; the job runs to FINISH.
  - A client must not re-raise req in the cycle of its own done/err.
  - req_addr and req_cnt are sampled only at grant.
- Simultaneous events:
  - sort_valid in the same cycle as the RUN->DRAIN transition is counted.
  - In FINISH, a new req from any client waits for IDLE.
- busy = (state != IDLE).
- Reset mid-job forces IDLE immediately (sort_req drops next edge). No done/err is issued for the aborted job.
- No outputs are combinational from inputs.

Test Plan:
- Client 1 req, addr 0x010, cnt 4; engine model holds sort_active for the run and emits 16 beats -> gnt=0010 one cycle after req, sort_req high until sort_active seen, done[1] pulse once after beat 16, start_addr=0x010 throughout.
- Clients 0, 2 and 3 request together, pointer at 0 -> grant order 2, 3, 0, then 2 again if re-requested. Exactly one gnt bit set at a time; ≥1 IDLE cycle between jobs.
- Client 0 cnt 0 -> no sort_req, err[0] pulse 2 cycles after req, busy back to 0.
- Engine never raises sort_active -> sort_req held for TMO cycles, then err pulse, sort_req 0.
- cnt 3 but engine emits only 7 beats after sort_active falls -> err after TMO idle cycles in DRAIN. Emitting 10 beats -> err on the 10th beat.
- rstb low mid-RUN for 1 cycle -> all outputs 0 next edge, state IDLE; a fresh req afterwards is granted normally with the pointer at 0.
